vga_console: RTL

//  CPU-side writer for the 80x25 text framebuffer in the vga block. Accepts a byte stream of

---
 rtl/vga_console_pkg.sv | 35 +++
 rtl/vga_console_if.sv | 19 +
 rtl/vga_console_bus_master.sv | 38 +++
 rtl/vga_console.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vga_console_pkg.sv
// Shared constants, state/op encodings and helpers for the console writer.
package vga_console_pkg;

    localparam int CharsAcross    = 80;
    localparam int CharsAcrossLog = 7;
    localparam int CharsDown      = 25;
    localparam int RowW           = 5;
    localparam int AddrW          = RowW + CharsAcrossLog;

    localparam logic [7:0] BlankChar = 8'h20;
    localparam logic [7:0] CharBs    = 8'h08;
    localparam logic [7:0] CharLf    = 8'h0A;
    localparam logic [7:0] CharFf    = 8'h0C;
    localparam logic [7:0] CharCr    = 8'h0D;

    localparam logic [CharsAcrossLog-1:0] LastCol = CharsAcrossLog'(CharsAcross - 1);
    localparam logic [RowW-1:0]           LastRow = RowW'(CharsDown - 1);
    localparam logic [RowW-1:0]           LastSrcDst = RowW'(CharsDown - 2);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PUT, ST_SC_RD, ST_SC_WAIT, ST_SC_WR, ST_CLR
    } console_state_e;

    typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR} bus_op_e;

    function automatic logic [AddrW-1:0] fb_addr(input logic [RowW-1:0] row,
                                                 input logic [CharsAcrossLog-1:0] col);
        return {row, col};
    endfunction

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/vga_console_if.sv
// Producer handshake, cursor and framebuffer control lines of the console writer.
interface vga_console_if;
    import vga_console_pkg::*;

    logic                      ch_valid;
    logic [7:0]                ch_data;
    logic                      ch_ready;
    logic [CharsAcrossLog-1:0] cur_col;
    logic [RowW-1:0]           cur_row;
    logic                      cs_;
    logic                      oe_;
    logic                      we_;
    logic [AddrW-1:0]          addr;

    modport master (input ch_valid, ch_data,
                    output ch_ready, cur_col, cur_row, cs_, oe_, we_, addr);
    modport slave  (output ch_valid, ch_data,
                    input ch_ready, cur_col, cur_row, cs_, oe_, we_, addr);
endinterface

// File: rtl/vga_console_bus_master.sv
// Registers the next-cycle bus op into cs_/oe_/we_/addr/write data so every
// framebuffer control line leaves the block straight from a flop.
module vga_console_bus_master
    import vga_console_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  bus_op_e          op_d,
    input  logic [AddrW-1:0] addr_d,
    input  logic [7:0]       wdata_d,
    output logic             cs_,
    output logic             oe_,
    output logic             we_,
    output logic [AddrW-1:0] addr,
    output logic [7:0]       wdata,
    output logic             drive
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_   <= 1'b1;
            oe_   <= 1'b1;
            we_   <= 1'b1;
            addr  <= '0;
            wdata <= '0;
        end else begin
            cs_ <= (op_d == OP_NONE);
            oe_ <= (op_d != OP_RD);
            we_ <= (op_d != OP_WR);
            // address is held while idle so it never glitches between ops
            if (op_d != OP_NONE) addr <= addr_d;
            if (op_d == OP_WR) wdata <= wdata_d;
        end
    end

    assign drive = !cs_ && !we_;

endmodule

// File: rtl/vga_console.sv
// Console writer: decodes the byte stream, keeps the cursor and runs clear/scroll.
// state      | meaning
// ST_IDLE    | waiting for a byte (ready unless just accepted or clear pending)
// ST_PUT     | single write of a printable byte at the cursor
// ST_SC_RD   | scroll: first read cycle of source cell
// ST_SC_WAIT | scroll: second read cycle, read data sampled at its end
// ST_SC_WR   | scroll: write sampled byte to destination cell
// ST_CLR     | blank writes (whole screen, or bottom row after scroll)
module vga_console
    import vga_console_pkg::*;
#(
    parameter bit ClearOnReset = 1'b1
)
(
    input  logic       clk,
    input  logic       rst,
    vga_console_if.master con,
    inout  wire  [7:0] data
);

    console_state_e            state, state_d;
    logic [CharsAcrossLog-1:0] col, col_d, cnt_col, cnt_col_d;
    logic [RowW-1:0]           row, row_d, cnt_row, cnt_row_d;
    logic                      took, clr_pend, accept, start_scroll;
    bus_op_e                   op_d;
    logic [AddrW-1:0]          addr_d;
    logic [7:0]                wdata_d, wdata;
    logic                      drive;

    assign con.ch_ready = (state == ST_IDLE) && !took && !clr_pend && !rst;
    assign accept       = con.ch_valid && con.ch_ready;
    assign con.cur_col  = col;
    assign con.cur_row  = row;
    assign data         = drive ? wdata : 8'hzz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            col      <= '0;
            row      <= '0;
            cnt_col  <= '0;
            cnt_row  <= '0;
            took     <= 1'b0;
            clr_pend <= ClearOnReset;
        end else begin
            state   <= state_d;
            col     <= col_d;
            row     <= row_d;
            cnt_col <= cnt_col_d;
            cnt_row <= cnt_row_d;
            took    <= accept;
            if (state_d == ST_CLR) clr_pend <= 1'b0;
        end
    end

    always_comb begin
        state_d      = state;
        col_d        = col;
        row_d        = row;
        cnt_col_d    = cnt_col;
        cnt_row_d    = cnt_row;
        op_d         = OP_NONE;
        addr_d       = fb_addr(cnt_row, cnt_col);
        wdata_d      = BlankChar;
        start_scroll = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (clr_pend) begin
                    state_d   = ST_CLR;
                    cnt_row_d = '0;
                    cnt_col_d = '0;
                    op_d      = OP_WR;
                    addr_d    = '0;
                end else if (accept) begin
                    if (is_printable(con.ch_data)) begin
                        state_d = ST_PUT;
                        op_d    = OP_WR;
                        addr_d  = fb_addr(row, col);
                        wdata_d = con.ch_data;
                    end else begin
                        case (con.ch_data)
                            CharCr: col_d = '0;
                            CharLf: begin
                                col_d = '0;
                                if (row == LastRow) start_scroll = 1'b1;
                                else row_d = row + RowW'(1);
                            end
                            CharBs: if (col != '0) col_d = col - CharsAcrossLog'(1);
                            CharFf: begin
                                col_d     = '0;
                                row_d     = '0;
                                state_d   = ST_CLR;
                                cnt_row_d = '0;
                                cnt_col_d = '0;
                                op_d      = OP_WR;
                                addr_d    = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_PUT: begin
                state_d = ST_IDLE;
                if (col == LastCol) begin
                    col_d = '0;
                    if (row == LastRow) start_scroll = 1'b1;
                    else row_d = row + RowW'(1);
                end else begin
                    col_d = col + CharsAcrossLog'(1);
                end
            end
            ST_SC_RD: begin
                state_d = ST_SC_WAIT;
                op_d    = OP_RD;
                addr_d  = fb_addr(cnt_row + RowW'(1), cnt_col);
            end
            ST_SC_WAIT: begin
                // registered RAM output is valid now; copy it straight into the write
                state_d = ST_SC_WR;
                op_d    = OP_WR;
                addr_d  = fb_addr(cnt_row, cnt_col);
                wdata_d = data;
            end
            ST_SC_WR: begin
                if (cnt_col == LastCol && cnt_row == LastSrcDst) begin
                    state_d   = ST_CLR;
                    cnt_row_d = LastRow;
                    cnt_col_d = '0;
                    op_d      = OP_WR;
                    addr_d    = fb_addr(LastRow, '0);
                end else begin
                    if (cnt_col == LastCol) begin
                        cnt_col_d = '0;
                        cnt_row_d = cnt_row + RowW'(1);
                    end else begin
                        cnt_col_d = cnt_col + CharsAcrossLog'(1);
                    end
                    state_d = ST_SC_RD;
                    op_d    = OP_RD;
                    addr_d  = fb_addr(cnt_row_d + RowW'(1), cnt_col_d);
                end
            end
            ST_CLR: begin
                if (cnt_col == LastCol && cnt_row == LastRow) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_col == LastCol) begin
                        cnt_col_d = '0;
                        cnt_row_d = cnt_row + RowW'(1);
                    end else begin
                        cnt_col_d = cnt_col + CharsAcrossLog'(1);
                    end
                    op_d   = OP_WR;
                    addr_d = fb_addr(cnt_row_d, cnt_col_d);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start_scroll) begin
            state_d   = ST_SC_RD;
            cnt_row_d = '0;
            cnt_col_d = '0;
            op_d      = OP_RD;
            addr_d    = fb_addr(RowW'(1), '0);
        end
    end

    vga_console_bus_master u_bus (
        .clk     (clk),
        .rst     (rst),
        .op_d    (op_d),
        .addr_d  (addr_d),
        .wdata_d (wdata_d),
        .cs_     (con.cs_),
        .oe_     (con.oe_),
        .we_     (con.we_),
        .addr    (con.addr),
        .wdata   (wdata),
        .drive   (drive)
    );

endmodule
